// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: run-state encodings, key masks and score helpers.
package game_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PLAY    = 2'd1;
  localparam state_t ST_RESPAWN = 2'd2;
  localparam state_t ST_OVER    = 2'd3;

  localparam logic [1:0] KEY_LEFT  = 2'b10;
  localparam logic [1:0] KEY_RIGHT = 2'b01;

  localparam int SCREEN_H = 480;

  localparam logic [13:0] SCORE_MAX = 14'h3FFF;

  function automatic logic [13:0] score_sat_inc(input logic [13:0] v);
    return (v == SCORE_MAX) ? v : v + 14'd1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_gen.sv
// Frame-tick prescaler: free-running while enabled, parked at zero otherwise.
module tick_gen #(
  parameter int DIV = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DIV-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = &cnt_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game run-state sequencer: frame tick, world reload pulses, key gating, lives and score.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 19,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 64,
  parameter int SCORE_EVERY   = 32,
  parameter int FALL_Y        = SCREEN_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic [1:0]  key_move,
  input  logic        hit_ceiling,
  input  logic [9:0]  slime_y,
  output logic        game_tick,
  output logic        world_rst,
  output logic [1:0]  move_key,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic [13:0] score
);

  localparam int SW = (SCORE_EVERY > 1) ? $clog2(SCORE_EVERY) : 1;
  localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
  localparam logic [SW-1:0] SC_LAST   = SW'(SCORE_EVERY - 1);
  localparam logic [RW-1:0] RSP_LAST  = RW'(RESPAWN_TICKS - 1);
  localparam logic [1:0]    LIVES_INI = 2'(LIVES);
  localparam logic [9:0]    FALL_LIM  = 10'(FALL_Y);

  state_t        state_reg, state_next;
  logic [1:0]    lives_reg, lives_next;
  logic [13:0]   score_reg, score_next;
  logic [SW-1:0] sc_cnt_reg, sc_cnt_next;
  logic [RW-1:0] rsp_cnt_reg, rsp_cnt_next;
  logic          world_rst_reg, world_rst_next;
  logic          game_tick_reg;
  logic [1:0]    move_key_reg;
  logic          tick_int;
  logic          death;

  // The reload request also clears the prescaler so the first frame tick lands a full period later.
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (world_rst_next),
    .en   ((state_reg == ST_PLAY) || (state_reg == ST_RESPAWN)),
    .tick (tick_int)
  );

  assign death = hit_ceiling || (slime_y >= FALL_LIM);

  always_comb begin
    state_next     = state_reg;
    lives_next     = lives_reg;
    score_next     = score_reg;
    sc_cnt_next    = sc_cnt_reg;
    rsp_cnt_next   = rsp_cnt_reg;
    world_rst_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (key_start) begin
          world_rst_next = 1'b1;
          lives_next     = LIVES_INI;
          score_next     = '0;
          sc_cnt_next    = '0;
          state_next     = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A death outranks a coincident frame tick, so the last frame earns nothing.
        if (death) begin
          if (lives_reg > 2'd1) begin
            lives_next   = lives_reg - 2'd1;
            rsp_cnt_next = '0;
            state_next   = ST_RESPAWN;
          end else begin
            lives_next = 2'd0;
            state_next = ST_OVER;
          end
        end else if (tick_int) begin
          if (sc_cnt_reg == SC_LAST) begin
            sc_cnt_next = '0;
            score_next  = score_sat_inc(score_reg);
          end else begin
            sc_cnt_next = sc_cnt_reg + 1'b1;
          end
        end
      end
      ST_RESPAWN: begin
        if (tick_int) begin
          if (rsp_cnt_reg == RSP_LAST) begin
            rsp_cnt_next   = '0;
            world_rst_next = 1'b1;
            state_next     = ST_PLAY;
          end else begin
            rsp_cnt_next = rsp_cnt_reg + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (key_start) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      lives_reg     <= LIVES_INI;
      score_reg     <= '0;
      sc_cnt_reg    <= '0;
      rsp_cnt_reg   <= '0;
      world_rst_reg <= 1'b0;
      game_tick_reg <= 1'b0;
      move_key_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      score_reg     <= score_next;
      sc_cnt_reg    <= sc_cnt_next;
      rsp_cnt_reg   <= rsp_cnt_next;
      world_rst_reg <= world_rst_next;
      game_tick_reg <= tick_int && (state_reg == ST_PLAY);
      move_key_reg  <= (state_reg == ST_PLAY) ? (key_move & (KEY_LEFT | KEY_RIGHT)) : 2'b00;
    end
  end

  assign game_tick = game_tick_reg;
  assign world_rst = world_rst_reg;
  assign move_key  = move_key_reg;
  assign state     = state_reg;
  assign lives     = lives_reg;
  assign score     = score_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: scripted game sequences plus a fast instance for score saturation.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, key_start, hit_ceiling;
  logic [1:0]  key_move;
  logic [9:0]  slime_y;
  logic        game_tick, world_rst;
  logic [1:0]  move_key, state, lives;
  logic [13:0] score;

  logic        key_start_b;
  logic        game_tick_b, world_rst_b;
  logic [1:0]  move_key_b, state_b, lives_b;
  logic [13:0] score_b;

  game_flow_ctrl #(
    .TICK_DIV(4), .LIVES(2), .RESPAWN_TICKS(2), .SCORE_EVERY(3), .FALL_Y(480)
  ) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_move(key_move),
    .hit_ceiling(hit_ceiling), .slime_y(slime_y), .game_tick(game_tick),
    .world_rst(world_rst), .move_key(move_key), .state(state), .lives(lives), .score(score)
  );

  // Fast-scoring instance: one point every two cycles, so saturation is reachable.
  game_flow_ctrl #(
    .TICK_DIV(1), .LIVES(1), .RESPAWN_TICKS(1), .SCORE_EVERY(1), .FALL_Y(480)
  ) dut_sat (
    .clk(clk), .rst(rst), .key_start(key_start_b), .key_move(2'b00),
    .hit_ceiling(1'b0), .slime_y(10'd0), .game_tick(game_tick_b),
    .world_rst(world_rst_b), .move_key(move_key_b), .state(state_b), .lives(lives_b),
    .score(score_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    string      name;
    logic [1:0] km;
    logic       ks;
    logic [1:0] exp_move;
    logic [1:0] exp_state;
    logic       exp_wrst;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard for the key path: expectation queued at drive time, checked when the output appears.
  task automatic drive_move(input logic [1:0] km, input logic [1:0] exp);
    logic [1:0] e;
    key_move = km;
    exp_q.push_back(exp);
    step();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("move_key", int'(move_key), int'(e));
    end
  endtask

  initial begin
    int cnt, cnt2, waited, got, bad;

    vecs[0] = '{"play_left",   2'b10, 1'b0, 2'b10, 2'd1, 1'b0};
    vecs[1] = '{"play_right",  2'b01, 1'b0, 2'b01, 2'd1, 1'b0};
    vecs[2] = '{"play_both_start", 2'b11, 1'b1, 2'b11, 2'd1, 1'b0};
    vecs[3] = '{"play_none_start", 2'b00, 1'b1, 2'b00, 2'd1, 1'b0};

    rst = 1'b1; key_start = 1'b0; key_move = 2'b00; hit_ceiling = 1'b0; slime_y = 10'd100;
    key_start_b = 1'b0;
    step();
    rst = 1'b0;

    // 1: reset state, then a long idle stretch
    chk("rst_state", int'(state), 0);
    chk("rst_lives", int'(lives), 2);
    chk("rst_score", int'(score), 0);
    chk("rst_game_tick", int'(game_tick), 0);
    chk("rst_world_rst", int'(world_rst), 0);
    chk("rst_move_key", int'(move_key), 0);
    key_move = 2'b10;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (game_tick || world_rst) cnt++;
      if (move_key != 2'b00) cnt2++;
    end
    chk("idle_no_tick", cnt, 0);
    chk("idle_move_gated", cnt2, 0);
    key_move = 2'b00;

    // 2: start, tick spacing and scoring
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    chk("start_world_rst", int'(world_rst), 1);
    chk("start_state", int'(state), 1);
    cnt = 0; bad = 0; cnt2 = 0;
    for (int i = 1; i <= 96; i++) begin
      step();
      if (i == 1) chk("world_rst_width", int'(world_rst), 0);
      if (world_rst) cnt2++;
      if (game_tick) begin
        cnt++;
        if (i % 16 != 0) bad++;
      end
      if (i == 16) chk("first_tick_at_16", int'(game_tick), 1);
      if (i == 47) chk("score_before_3rd", int'(score), 0);
      if (i == 48) chk("score_after_3rd", int'(score), 1);
      if (i == 96) chk("score_after_6th", int'(score), 2);
    end
    chk("tick_count", cnt, 6);
    chk("tick_misplaced", bad, 0);
    chk("play_no_reload", cnt2, 0);

    // 5: key gating and ignored start in PLAY, table-driven
    foreach (vecs[k]) begin
      key_start = vecs[k].ks;
      drive_move(vecs[k].km, vecs[k].exp_move);
      key_start = 1'b0;
      chk({vecs[k].name, "_state"}, int'(state), int'(vecs[k].exp_state));
      chk({vecs[k].name, "_wrst"}, int'(world_rst), int'(vecs[k].exp_wrst));
    end

    // 3: fall -> RESPAWN, deaths ignored, reload after two ticks
    slime_y = 10'd480;
    drive_move(2'b10, 2'b10);
    slime_y = 10'd100;
    chk("fall_state", int'(state), 2);
    chk("fall_lives", int'(lives), 1);
    chk("fall_score", int'(score), 2);
    drive_move(2'b10, 2'b00);
    key_move = 2'b00;
    hit_ceiling = 1'b1;
    waited = 0; got = 0; cnt = 0;
    for (int i = 1; i <= 100 && got == 0; i++) begin
      step();
      waited = i;
      if (i == 5) hit_ceiling = 1'b0;
      if (world_rst) got = 1;
      else if (game_tick) cnt++;
    end
    hit_ceiling = 1'b0;
    chk("respawn_reload_seen", got, 1);
    chk("respawn_length", waited, 26);
    chk("respawn_no_game_tick", cnt, 0);
    chk("reload_state", int'(state), 1);
    chk("respawn_lives_kept", int'(lives), 1);
    chk("respawn_score_frozen", int'(score), 2);

    // 4: last life lost on a tick cycle -> OVER without scoring
    cnt = 0;
    for (int i = 1; i <= 47; i++) begin
      step();
      if (i == 1) chk("reload_width", int'(world_rst), 0);
      if (game_tick) cnt++;
    end
    chk("replay_ticks", cnt, 2);
    chk("replay_score", int'(score), 2);
    hit_ceiling = 1'b1;
    step();
    hit_ceiling = 1'b0;
    chk("over_state", int'(state), 3);
    chk("over_lives", int'(lives), 0);
    chk("over_no_score_inc", int'(score), 2);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (game_tick) cnt++;
    end
    chk("over_no_tick", cnt, 0);
    chk("over_score_held", int'(score), 2);
    drive_move(2'b10, 2'b00);
    key_move = 2'b00;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    chk("over_to_idle", int'(state), 0);
    chk("over_to_idle_no_wrst", int'(world_rst), 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (world_rst || state != 2'd0) cnt++;
    end
    chk("idle_waits_for_start", cnt, 0);

    // 6: reset in the middle of RESPAWN
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    chk("restart_wrst", int'(world_rst), 1);
    chk("restart_lives", int'(lives), 2);
    chk("restart_score_cleared", int'(score), 0);
    for (int i = 0; i < 48; i++) step();
    chk("restart_score", int'(score), 1);
    slime_y = 10'd500;
    step();
    slime_y = 10'd100;
    chk("fall2_state", int'(state), 2);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_state", int'(state), 0);
    chk("midrst_lives", int'(lives), 2);
    chk("midrst_score", int'(score), 0);
    chk("midrst_world_rst", int'(world_rst), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (world_rst || game_tick || state != 2'd0) cnt++;
    end
    chk("midrst_stays_idle", cnt, 0);

    // Score saturation on the fast instance
    key_start_b = 1'b1;
    step();
    key_start_b = 1'b0;
    chk("sat_start_state", int'(state_b), 1);
    got = 0;
    for (int i = 0; i < 40000 && got == 0; i++) begin
      step();
      if (score_b == 14'h3FFF) got = 1;
    end
    chk("sat_reached", got, 1);
    for (int i = 0; i < 10; i++) step();
    chk("sat_held", int'(score_b), 16383);
    chk("sat_still_play", int'(state_b), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
